// File: rtl/finn_rtl_krnl_final_example_pkg.sv
// Shared types and constants for the stream checker kernel.
// Optional backpressure build: define FINN_CHK_BACKPRESSURE_EN.
package finn_rtl_krnl_final_example_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } chk_state_t;

  localparam int ERR_DATA  = 0;
  localparam int ERR_KEEP  = 1;
  localparam int ERR_EARLY = 2;
  localparam int ERR_MISS  = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned calc_num_beats(
    input int unsigned len_bytes,
    input int unsigned width_bits
  );
    return len_bytes / (width_bits / 8);
  endfunction

endpackage

// File: rtl/finn_rtl_krnl_final_example_lfsr.sv
// Fibonacci LFSR used as a pseudo-random tready source.
// Only instantiated when FINN_CHK_BACKPRESSURE_EN is defined.
module finn_rtl_krnl_final_example_lfsr
  import finn_rtl_krnl_final_example_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic bit_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // reload on start, otherwise shift while enabled
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)
      lfsr_d = SEED;
    else if (en_i)
      lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= SEED;
    else
      lfsr_q <= lfsr_d;
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/finn_rtl_krnl_final_example_stream_checker.sv
// AXI4-Stream sink checking count+constant lanes and tlast/tkeep framing.
// Optional backpressure build: define FINN_CHK_BACKPRESSURE_EN.
module finn_rtl_krnl_final_example_stream_checker
  import finn_rtl_krnl_final_example_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 512,
  parameter int C_NUMBER_BIT_WIDTH   = 32,
  parameter int C_LENGTH_IN_BYTES    = 16384
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              ap_start,
  output logic                              ap_done,
  input  logic [31:0]                       ctrl_constant,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              pass,
  output logic [15:0]                       err_count,
  output logic [3:0]                        err_flags,
  output logic [31:0]                       first_err_beat
);

  localparam int LW    = C_NUMBER_BIT_WIDTH;
  localparam int LANES = C_S_AXIS_TDATA_WIDTH / LW;
  localparam int unsigned NB =
    calc_num_beats(C_LENGTH_IN_BYTES, C_S_AXIS_TDATA_WIDTH);
  localparam logic [31:0] LAST_BEAT = 32'(NB - 1);
  localparam logic [31:0] BASE_STEP = 32'(LANES);

  chk_state_t state_q, state_d;

  logic [31:0]      beat_q, beat_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      const_q, const_d;
  logic [LANES-1:0] mis_q, mis_d;
  logic             keep_q, early_q, miss_q;
  logic             vld_q;
  logic [31:0]      idx_q;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       flags_q, flags_d;
  logic [31:0]      first_q, first_d;
  logic             hit_q, hit_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_new;

  logic start, run, acc, is_last, term;

  assign start   = (state_q == IDLE) & ap_start;
  assign run     = (state_q == RUN);
  assign acc     = s_axis_tvalid & s_axis_tready;
  assign is_last = (beat_q == LAST_BEAT);
  assign term    = acc & (s_axis_tlast | is_last);

`ifdef FINN_CHK_BACKPRESSURE_EN
  logic bp_bit;

  finn_rtl_krnl_final_example_lfsr #(
    .WIDTH (16),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk    (aclk),
    .rst_n  (aresetn),
    .load_i (start),
    .en_i   (run),
    .bit_o  (bp_bit)
  );

  assign s_axis_tready = run & bp_bit;
`else
  assign s_axis_tready = run;
`endif

  assign ap_done        = (state_q == DONE);
  assign pass           = pass_q;
  assign err_count      = cnt_q;
  assign err_flags      = flags_q;
  assign first_err_beat = first_q;

  // control FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ap_start) state_d = RUN;
      RUN:     if (term) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // per-lane compare against base + lane + constant
  always_comb begin
    mis_d = '0;
    for (int i = 0; i < LANES; i++)
      mis_d[i] = s_axis_tdata[LW*i +: LW]
               != (base_q + const_q + 32'(i));
  end

  // beat counter, expected base and latched constant
  always_comb begin
    beat_d  = beat_q;
    base_d  = base_q;
    const_d = const_q;
    if (start) begin
      beat_d  = '0;
      base_d  = '0;
      const_d = ctrl_constant;
    end else if (acc) begin
      beat_d = beat_q + 32'd1;
      base_d = base_q + BASE_STEP;
    end
  end

  // retire staged compare into statistics
  always_comb begin
    err_new           = '0;
    err_new[ERR_DATA] = |mis_q;
    err_new[ERR_KEEP] = keep_q;
    err_new[ERR_EARLY] = early_q;
    err_new[ERR_MISS] = miss_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    first_d = first_q;
    hit_d   = hit_q;
    pass_d  = pass_q;
    if (start) begin
      cnt_d   = '0;
      flags_d = '0;
      first_d = '1;
      hit_d   = 1'b0;
      pass_d  = 1'b0;
    end else begin
      if (vld_q) begin
        flags_d = flags_q | err_new;
        if (err_new[ERR_DATA] && cnt_q != 16'hFFFF)
          cnt_d = cnt_q + 16'd1;
        if (|err_new && !hit_q) begin
          first_d = idx_q;
          hit_d   = 1'b1;
        end
      end
      if (state_q == DRAIN)
        pass_d = (cnt_d == '0) && (flags_d == '0);
    end
  end

  // FSM and run-tracking registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      const_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      const_q <= const_d;
    end
  end

  // compare stage captured on each accepted beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q   <= 1'b0;
      mis_q   <= '0;
      keep_q  <= 1'b0;
      early_q <= 1'b0;
      miss_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      vld_q <= acc;
      if (acc) begin
        mis_q   <= mis_d;
        keep_q  <= ~&s_axis_tkeep;
        early_q <= s_axis_tlast & ~is_last;
        miss_q  <= ~s_axis_tlast & is_last;
        idx_q   <= beat_q;
      end
    end
  end

  // result registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q   <= '0;
      flags_q <= '0;
      first_q <= '1;
      hit_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      first_q <= first_d;
      hit_q   <= hit_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_finn_rtl_krnl_final_example_stream_checker.sv
// Randomized bench for the stream checker with a frame-level model.
// Works with or without FINN_CHK_BACKPRESSURE_EN.
module tb_finn_rtl_krnl_final_example_stream_checker;

  localparam int W     = 512;
  localparam int LEN   = 256;
  localparam int NB    = LEN / (W / 8);
  localparam int LANES = W / 32;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           ap_start;
  logic           ap_done;
  logic [31:0]    ctrl_constant;
  logic           tvalid;
  logic           tready;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tkeep;
  logic           tlast;
  logic           pass;
  logic [15:0]    err_count;
  logic [3:0]     err_flags;
  logic [31:0]    first_err_beat;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  finn_rtl_krnl_final_example_stream_checker #(
    .C_S_AXIS_TDATA_WIDTH (W),
    .C_NUMBER_BIT_WIDTH   (32),
    .C_LENGTH_IN_BYTES    (LEN)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ctrl_constant  (ctrl_constant),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tlast   (tlast),
    .pass           (pass),
    .err_count      (err_count),
    .err_flags      (err_flags),
    .first_err_beat (first_err_beat)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_tready"}, tready, 0);
    chk({p, "_done"}, ap_done, 0);
    chk({p, "_pass"}, pass, 0);
    chk({p, "_cnt"}, err_count, 0);
    chk({p, "_flags"}, err_flags, 0);
    chk({p, "_first"}, first_err_beat, 32'hFFFF_FFFF);
  endtask

  function automatic logic [W-1:0] mk_beat(input int b,
                                           input logic [31:0] cst,
                                           input int bad_lane);
    logic [W-1:0] d;
    logic [31:0]  v;
    for (int i = 0; i < LANES; i++) begin
      v = 32'(b * LANES + i) + cst;
      if (i == bad_lane) v = v + 32'd1;
      d[32*i +: 32] = v;
    end
    return d;
  endfunction

  // tl/keep_bad: per-beat bit masks; cor_beat/cor_lane: one corrupted lane
  task automatic run_frame(input string nm,
                           input logic [31:0] cst,
                           input logic [3:0] tl,
                           input logic [3:0] keep_bad,
                           input int cor_beat,
                           input int cor_lane,
                           input bit hold_start);
    int          m_acc;
    int          ecnt;
    logic [3:0]  fl;
    logic [31:0] fe;
    bit          e, seen, ok;
    int          acc_cyc;
    m_acc = 0; ecnt = 0; fl = '0; fe = '1; seen = 0;
    for (int b = 0; b < NB; b++) begin
      m_acc++;
      e = 0;
      if (cor_beat == b) begin ecnt++; fl[0] = 1; e = 1; end
      if (keep_bad[b]) begin fl[1] = 1; e = 1; end
      if (tl[b] && b < NB - 1) begin fl[2] = 1; e = 1; end
      if (!tl[b] && b == NB - 1) begin fl[3] = 1; e = 1; end
      if (e && !seen) begin fe = 32'(b); seen = 1; end
      if (tl[b] || b == NB - 1) break;
    end

    ap_start      = 1'b1;
    ctrl_constant = cst;
    @(posedge aclk); #1;
    if (!hold_start) ap_start = 1'b0;
    ctrl_constant = $urandom;

    acc_cyc = 0;
    for (int b = 0; b < m_acc; b++) begin
      repeat ($urandom_range(0, 2)) begin
        tvalid = 1'b0;
        tdata  = {16{$urandom}};
        @(posedge aclk); #1;
      end
      tvalid = 1'b1;
      tdata  = mk_beat(b, cst, (cor_beat == b) ? cor_lane : -1);
      tkeep  = keep_bad[b] ? '0 : '1;
      tlast  = tl[b];
      ok = 0;
      for (int t = 0; t < 100; t++) begin
        @(negedge aclk);
        if (tready) begin ok = 1; break; end
        @(posedge aclk); #1;
      end
      if (!ok) begin
        chk({nm, "_accept_timeout"}, 0, 1);
        tvalid = 1'b0;
        return;
      end
      acc_cyc = cyc;
      @(posedge aclk); #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tkeep  = '1;
    end
    ap_start = 1'b0;
    chk({nm, "_tready_drop"}, tready, 0);

    for (int t = 0; t < 20; t++) begin
      @(negedge aclk);
      if (ap_done) break;
    end
    chk({nm, "_done_lat"}, cyc - acc_cyc, 2);
    chk({nm, "_pass"}, pass, (ecnt == 0 && fl == 0));
    chk({nm, "_cnt"}, err_count, ecnt);
    chk({nm, "_flags"}, err_flags, fl);
    chk({nm, "_first"}, first_err_beat, fe);
    @(posedge aclk); #1;
    repeat (3) @(posedge aclk);
    #1;
    chk({nm, "_idle_done"}, ap_done, 0);
    chk({nm, "_pass_hold"}, pass, (ecnt == 0 && fl == 0));
  endtask

  initial begin
    logic [3:0] tl, kb;
    int         cb;
    aresetn       = 1'b0;
    ap_start      = 1'b0;
    ctrl_constant = '0;
    tvalid        = 1'b0;
    tdata         = '0;
    tkeep         = '1;
    tlast         = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk_reset("rst");
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    run_frame("t1_clean", 32'd5, 4'b1000, 4'b0000, -1, 0, 0);
    run_frame("t2_lane", 32'd5, 4'b1000, 4'b0000, 1, 2, 0);
    run_frame("t3_early", 32'd5, 4'b0010, 4'b0000, -1, 0, 0);
    run_frame("t4_miss", 32'd5, 4'b0000, 4'b0000, -1, 0, 0);
    run_frame("t4_keep", 32'd5, 4'b1000, 4'b0001, -1, 0, 0);
    run_frame("t5_wrap", 32'hFFFF_FFFE, 4'b1000, 4'b0000, -1, 0, 1);

    // mid-run reset after one bad-tkeep beat has retired
    ap_start = 1'b1;
    ctrl_constant = 32'd9;
    @(posedge aclk); #1;
    ap_start = 1'b0;
    tvalid = 1'b1;
    tdata  = mk_beat(0, 32'd9, -1);
    tkeep  = '0;
    for (int t = 0; t < 100; t++) begin
      @(negedge aclk);
      if (tready) break;
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    tvalid = 1'b0;
    tkeep  = '1;
    repeat (2) @(posedge aclk);
    #1;
    chk("t6_pre_flags", err_flags, 4'b0010);
    #2 aresetn = 1'b0;
    #1;
    chk_reset("t6_rst");
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int r = 0; r < 12; r++) begin
      tl = ($urandom_range(0, 1) == 0) ? 4'b1000
                                       : 4'($urandom_range(0, 15));
      kb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
                                       : 4'b0000;
      cb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NB - 1) : -1;
      run_frame($sformatf("rnd%0d", r), $urandom, tl, kb, cb,
                $urandom_range(0, LANES - 1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
